// File: rtl/burst_ctrl_if.sv
// Signal bundle between the front end, the frequency generator and burst_ctrl.
// The master side drives the request fields and gen_out; burst_ctrl is the slave.
interface burst_ctrl_if #(
    parameter int PARAM_W = 8,
    parameter int ON_W    = 8,
    parameter int OFF_W   = 16
);
    logic               start;
    logic [ON_W-1:0]    on_cycles;
    logic [OFF_W-1:0]   off_time;
    logic [PARAM_W-1:0] freq_param;
    logic               gen_out;
    logic               gen_en;
    logic [PARAM_W-1:0] gen_inp;
    logic               drive;
    logic               busy;
    logic               burst_done;
    logic               fault;

    modport master (
        output start, on_cycles, off_time, freq_param, gen_out,
        input  gen_en, gen_inp, drive, busy, burst_done, fault
    );

    modport slave (
        input  start, on_cycles, off_time, freq_param, gen_out,
        output gen_en, gen_inp, drive, busy, burst_done, fault
    );
endinterface

// File: rtl/burst_ctrl.sv
// Burst sequencer: loads the generator, syncs to its first rise and gates N half-cycles,
// then holds an off-time. Define BURST_SWEEP_EN to step gen_inp up on every in-burst rise.
module burst_ctrl #(
    parameter int PARAM_W  = 8,
    parameter int ON_W     = 8,
    parameter int OFF_W    = 16,
    parameter int PRESC    = 100,
    parameter int SYNC_TMO = 1024
) (
    input  logic        clk,
    input  logic        rst,
    burst_ctrl_if.slave bus
);
    localparam int PRESC_W = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int TMO_W   = (SYNC_TMO > 1) ? $clog2(SYNC_TMO) : 1;

    typedef enum logic [1:0] {IDLE, SYNC, BURST, OFF} state_t;

    state_t             state_q, state_d;
    logic               gen_q, gen_d;
    logic [ON_W-1:0]    on_lat_q, on_lat_d;
    logic [ON_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic [OFF_W-1:0]   off_lat_q, off_lat_d;
    logic [OFF_W-1:0]   off_cnt_q, off_cnt_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [PARAM_W-1:0] gen_inp_q, gen_inp_d;
    logic               gen_en_q, gen_en_d;
    logic               drive_q, drive_d;
    logic               busy_q, busy_d;
    logic               burst_done_q, burst_done_d;
    logic               fault_q, fault_d;

    logic gen_rise, gen_edge, load_ok, off_done, do_load;

    assign gen_rise = bus.gen_out & ~gen_q;
    assign gen_edge = bus.gen_out ^ gen_q;
    assign load_ok  = bus.start && (bus.on_cycles != '0);
    assign off_done = (off_lat_q == '0) ||
                      ((off_cnt_q == off_lat_q - OFF_W'(1)) && (presc_q == PRESC_W'(PRESC - 1)));

    always_comb begin
        state_d      = state_q;
        gen_d        = bus.gen_out;
        on_lat_d     = on_lat_q;
        edge_cnt_d   = edge_cnt_q;
        off_lat_d    = off_lat_q;
        off_cnt_d    = off_cnt_q;
        presc_d      = presc_q;
        tmo_d        = tmo_q;
        gen_inp_d    = gen_inp_q;
        gen_en_d     = 1'b0;
        drive_d      = 1'b0;
        burst_done_d = 1'b0;
        fault_d      = 1'b0;
        do_load      = 1'b0;

        case (state_q)
            IDLE: do_load = load_ok;
            SYNC: begin
                if (gen_rise) begin
                    state_d    = BURST;
                    edge_cnt_d = '0;
                    drive_d    = 1'b1;
                end else if (tmo_q == TMO_W'(SYNC_TMO - 1)) begin
                    fault_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            BURST: begin
                drive_d = bus.gen_out;
`ifdef BURST_SWEEP_EN
                // The syncing rise was consumed in SYNC, so every rise seen here is a later one.
                if (gen_rise) begin
                    gen_en_d = 1'b1;
                    if (gen_inp_q != '1)
                        gen_inp_d = gen_inp_q + PARAM_W'(1);
                end
`endif
                if (gen_edge) begin
                    if (edge_cnt_q == on_lat_q - ON_W'(1)) begin
                        drive_d      = 1'b0;
                        burst_done_d = 1'b1;
                        off_lat_d    = bus.off_time;
                        off_cnt_d    = '0;
                        presc_d      = '0;
                        state_d      = OFF;
                    end else begin
                        edge_cnt_d = edge_cnt_q + ON_W'(1);
                    end
                end
            end
            OFF: begin
                if (off_done) begin
                    if (load_ok)
                        do_load = 1'b1;
                    else
                        state_d = IDLE;
                end else if (presc_q == PRESC_W'(PRESC - 1)) begin
                    presc_d   = '0;
                    off_cnt_d = off_cnt_q + OFF_W'(1);
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Shared by IDLE and OFF exit so a repeating burst reloads the generator identically.
        if (do_load) begin
            on_lat_d  = bus.on_cycles;
            gen_inp_d = bus.freq_param;
            gen_en_d  = 1'b1;
            tmo_d     = '0;
            state_d   = SYNC;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            gen_q        <= 1'b0;
            on_lat_q     <= '0;
            edge_cnt_q   <= '0;
            off_lat_q    <= '0;
            off_cnt_q    <= '0;
            presc_q      <= '0;
            tmo_q        <= '0;
            gen_inp_q    <= '0;
            gen_en_q     <= 1'b0;
            drive_q      <= 1'b0;
            busy_q       <= 1'b0;
            burst_done_q <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            gen_q        <= gen_d;
            on_lat_q     <= on_lat_d;
            edge_cnt_q   <= edge_cnt_d;
            off_lat_q    <= off_lat_d;
            off_cnt_q    <= off_cnt_d;
            presc_q      <= presc_d;
            tmo_q        <= tmo_d;
            gen_inp_q    <= gen_inp_d;
            gen_en_q     <= gen_en_d;
            drive_q      <= drive_d;
            busy_q       <= busy_d;
            burst_done_q <= burst_done_d;
            fault_q      <= fault_d;
        end
    end

    assign bus.gen_en     = gen_en_q;
    assign bus.gen_inp    = gen_inp_q;
    assign bus.drive      = drive_q;
    assign bus.busy       = busy_q;
    assign bus.burst_done = burst_done_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_burst_ctrl.sv
// Bench for burst_ctrl: a precomputed stimulus timeline (directed segments then random)
// and an event-level burst model that predicts every output cycle by cycle.
module tb_burst_ctrl;
    localparam int PARAM_W  = 8;
    localparam int ON_W     = 8;
    localparam int OFF_W    = 16;
    localparam int PRESC    = 4;
    localparam int SYNC_TMO = 16;
    localparam int NC       = 4000;
    localparam int MAXP     = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;

    burst_ctrl_if #(.PARAM_W(PARAM_W), .ON_W(ON_W), .OFF_W(OFF_W)) bus ();

    burst_ctrl #(
        .PARAM_W(PARAM_W), .ON_W(ON_W), .OFF_W(OFF_W), .PRESC(PRESC), .SYNC_TMO(SYNC_TMO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    bit s_rst[NC], s_start[NC], s_gen[NC];
    int s_on[NC], s_off[NC], s_fp[NC];
    bit e_drive[NC], e_en[NC], e_busy[NC], e_done[NC], e_fault[NC];
    int e_inp[NC];

    int checks = 0;
    int errors = 0;
    bit gen_level = 1'b0;
    int gen_cnt = 0;

    task automatic fillSeg(input int from, input int len, input int hp, input bit stuck,
                           input bit st, input int on, input int off, input int fp);
        for (int k = from; k < from + len && k < NC; k++) begin
            if (stuck) begin
                gen_level = 1'b0;
            end else begin
                gen_cnt++;
                if (gen_cnt >= hp) begin
                    gen_cnt = 0;
                    gen_level = ~gen_level;
                end
            end
            s_gen[k] = gen_level; s_start[k] = st; s_on[k] = on;
            s_off[k] = off; s_fp[k] = fp; s_rst[k] = 1'b0;
        end
    endtask

    task automatic put(input int k, input bit d, input bit en, input bit b,
                       input bit dn, input bit f, input int inp);
        e_drive[k] = d; e_en[k] = en; e_busy[k] = b;
        e_done[k] = dn; e_fault[k] = f; e_inp[k] = inp;
    endtask

    // One burst from its load cycle L; nxt is the first cycle that behaves like IDLE again.
    task automatic runBurst(input int L, inout int inp, output int nxt);
        int n, r, e, cnt, m, c;
        bit en;
        n = s_on[L]; r = -1; e = -1; cnt = 0;
        inp = s_fp[L];
        put(L, 0, 1, 1, 0, 0, inp);
        for (int j = 1; j <= SYNC_TMO; j++) begin
            c = L + j;
            if (c >= NC) begin nxt = NC; return; end
            if (s_rst[c]) begin nxt = c; return; end
            if (s_gen[c] && !s_gen[c-1]) begin r = c; break; end
            put(c, 0, 0, 1, 0, 0, inp);
        end
        if (r < 0) begin
            put(L + SYNC_TMO, 0, 0, 0, 0, 1, inp);
            nxt = L + SYNC_TMO + 1;
            return;
        end
        put(r, 1, 0, 1, 0, 0, inp);
        c = r + 1;
        while (e < 0) begin
            if (c >= NC) begin nxt = NC; return; end
            if (s_rst[c]) begin nxt = c; return; end
            en = 1'b0;
            if (s_gen[c] != s_gen[c-1]) begin
                cnt++;
`ifdef BURST_SWEEP_EN
                if (s_gen[c]) begin
                    en = 1'b1;
                    if (inp < MAXP) inp++;
                end
`endif
            end
            if (cnt == n) begin
                put(c, 0, en, 1, 1, 0, inp);
                e = c;
            end else begin
                put(c, s_gen[c], en, 1, 0, 0, inp);
            end
            c++;
        end
        m = (s_off[e] == 0) ? 1 : s_off[e] * PRESC;
        for (int k = e + 1; k < e + m; k++) begin
            if (k >= NC) begin nxt = NC; return; end
            if (s_rst[k]) begin nxt = k; return; end
            put(k, 0, 0, 1, 0, 0, inp);
        end
        nxt = e + m;
    endtask

    task automatic buildModel();
        int k, inp, nxt;
        k = 0; inp = 0;
        while (k < NC) begin
            if (s_rst[k]) begin
                inp = 0;
                put(k, 0, 0, 0, 0, 0, inp);
                k++;
            end else if (s_start[k] && s_on[k] != 0) begin
                runBurst(k, inp, nxt);
                k = nxt;
            end else begin
                put(k, 0, 0, 0, 0, 0, inp);
                k++;
            end
        end
    endtask

    task automatic applyStimulus(input int k);
        rst            = s_rst[k];
        bus.start      = s_start[k];
        bus.on_cycles  = ON_W'(s_on[k]);
        bus.off_time   = OFF_W'(s_off[k]);
        bus.freq_param = PARAM_W'(s_fp[k]);
        bus.gen_out    = s_gen[k];
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    task automatic compareCycle(input int k);
        checkOutput($sformatf("drive@%0d", k), 32'(bus.drive), 32'(e_drive[k]));
        checkOutput($sformatf("gen_en@%0d", k), 32'(bus.gen_en), 32'(e_en[k]));
        checkOutput($sformatf("busy@%0d", k), 32'(bus.busy), 32'(e_busy[k]));
        checkOutput($sformatf("burst_done@%0d", k), 32'(bus.burst_done), 32'(e_done[k]));
        checkOutput($sformatf("fault@%0d", k), 32'(bus.fault), 32'(e_fault[k]));
        checkOutput($sformatf("gen_inp@%0d", k), 32'(bus.gen_inp), 32'(e_inp[k]));
    endtask

    initial begin
        int k, len;
        bus.start = 1'b0; bus.on_cycles = '0; bus.off_time = '0;
        bus.freq_param = '0; bus.gen_out = 1'b0;

        // Directed segments: idle, repeating 6-half-cycle bursts, off-time, start drop,
        // stuck generator, saturating sweep, reset while drive is high.
        fillSeg(0, 205, 4, 0, 0, 6, 0, 'h20);
        for (int i = 0; i < 3; i++) s_rst[i] = 1'b1;
        fillSeg(205, 180, 4, 0, 1, 6, 0, 'h20);
        fillSeg(385, 150, 4, 0, 1, 3, 2, 'h55);  s_rst[385] = 1'b1;
        fillSeg(535, 20, 4, 0, 1, 10, 1, 'h33);  s_rst[535] = 1'b1;
        fillSeg(555, 150, 4, 0, 0, 10, 1, 'h33);
        fillSeg(705, 60, 4, 1, 1, 5, 0, 'h10);   s_rst[705] = 1'b1;
        fillSeg(765, 140, 3, 0, 1, 8, 1, 'hFE);  s_rst[765] = 1'b1;
        fillSeg(905, 60, 5, 0, 1, 12, 0, 'h40);  s_rst[905] = 1'b1;

        k = 965;
        while (k < NC) begin
            len = $urandom_range(10, 60);
            fillSeg(k, len, $urandom_range(2, 7), ($urandom_range(0, 7) == 0),
                    ($urandom_range(0, 9) < 7), $urandom_range(0, 12),
                    $urandom_range(0, 3), $urandom_range(0, 255));
            for (int i = k; i < k + len && i < NC; i++)
                if ($urandom_range(0, 149) == 0) s_rst[i] = 1'b1;
            k += len;
        end

        buildModel();
        for (int i = 906; i < 960; i++) begin
            if (e_drive[i]) begin
                s_rst[i+1] = 1'b1;
                break;
            end
        end
        buildModel();

        for (int i = 0; i < NC; i++) begin
            @(negedge clk);
            if (i > 0) compareCycle(i - 1);
            applyStimulus(i);
        end
        @(negedge clk);
        compareCycle(NC - 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/burst_ctrl.md
# burst_ctrl

Burst sequencer (interrupter) for the half-bridge frequency generator. Loads the generator's period parameter, aligns to its square-wave output, and gates it into bursts of a programmed number of half-cycles. Between bursts it holds a programmed off-time. It sits between the user/timing front end and the gate-drive output, owning the generator's `en`/`inp` pair.

## Interface
- `PARAM_W`, 8: width of generator period parameter.
- `ON_W`, 8: width of on-time, counted in generator half-cycles.
- `OFF_W`, 16: width of off-time, counted in `PRESC` units.
- `PRESC`, 100: clk cycles per off-time unit (1 us at 100 MHz).
- `SYNC_TMO`, 1024: max clk cycles waiting for generator edge.
- `clk` in 1: system clock, all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: level; while high, bursts repeat.
- `on_cycles` in ON_W: half-cycles per burst; sampled at burst load; 0 = no burst.
- `off_time` in OFF_W: off period; sampled on BURST→OFF.
- `freq_param` in PARAM_W: generator parameter; sampled at burst load.
- `gen_out` in 1: generator square-wave output.
- `gen_en` out 1: one-cycle load strobe to generator `en`.
- `gen_inp` out PARAM_W: parameter to generator `inp`.
- `drive` out 1: gated drive output.
- `busy` out 1: high in every state except IDLE.
- `burst_done` out 1: one-cycle pulse at burst end.
- `fault` out 1: one-cycle pulse on sync timeout.

## Operation
- All outputs registered. Reset values: `drive`, `gen_en`, `busy`, `burst_done`, `fault` = 0; `gen_inp` = 0. State = IDLE; all counters = 0.
- Edge detect: `gen_q` <= `gen_out` every cycle.
  - Rise = `gen_out & ~gen_q`.
  - Edge = `gen_out ^ gen_q`.
- States: IDLE, SYNC, BURST, OFF.
- Load condition: `start`=1 and `on_cycles`≠0.
- IDLE: on load condition:
  - latch `on_cycles`;
  - `gen_inp` <= `freq_param`; `gen_en` <= 1 for one cycle;
  - go to SYNC, clear timeout counter.
- SYNC: `drive`=0.
  - On rise: go to BURST, clear edge counter.
  - Else if timeout counter = SYNC_TMO-1: pulse `fault`, go to IDLE.
  - Else increment timeout counter.
- BURST: `drive` <= `gen_out` each cycle.
  - On each edge, increment edge counter.
  - On the edge where counter = latched on_cycles-1: `drive` <= 0, pulse `burst_done`, latch `off_time`, go to OFF.
- OFF: `drive`=0. Prescaler counts PRESC cycles per unit.
  - Exits after `off_time` units; `off_time`=0 gives exactly one cycle in OFF.
  - On exit: if load condition holds, perform the IDLE load actions and go to SYNC; else go to IDLE.
- `start` falling mid-burst: burst completes in full, off-time is honoured, then IDLE.
- Input changes after load have no effect on the current burst (`on_cycles`, `freq_param`) or current off period (`off_time`).
- `rst` in any state: next cycle `drive`=0, state IDLE, all counters cleared.
- Counters: edge counter is ON_W bits; off counter is OFF_W bits; no wrap is possible within the legal range.

## Timing
- Load → `gen_en` high on the cycle after the load condition is seen in IDLE or at OFF exit.
- Rise at `gen_out` in cycle t (seen in SYNC) → `drive`=1 at t+1.
- In BURST, `drive` tracks `gen_out` with exactly 1-cycle latency.
- Burst length: exactly `on_cycles` half-cycles.
  - The first half-cycle is high.
  - `drive` falls on the cycle after the N-th edge; `burst_done` pulses in that same cycle.
- Off interval: `off_time`·PRESC cycles from BURST exit to next SYNC entry (1 cycle if `off_time`=0).

## Configuration
- `BURST_SWEEP_EN` defined:
  - In BURST, on every rise of `gen_out` after the first, `gen_inp` increments by 1, saturating at all-ones.
  - `gen_en` pulses in the same cycle as each increment.
  - This lowers frequency through the burst to track resonance.
- Undefined: `gen_inp` is constant for the whole burst; `gen_en` pulses only at load.

## Test plan
- Reset, `start`=0; generator model with half-period 4 clk → `drive`, `busy`, `gen_en` stay 0 for 200 cycles.
- `start`=1, `on_cycles`=6, `freq_param`=0x20, `off_time`=0, half-period 4 → sequence:
  - `gen_en` 1-cycle pulse with `gen_inp`=0x20;
  - `drive` = 3 full periods starting 1 cycle after the first rise;
  - `burst_done` pulse; bursts repeat with a 1-cycle OFF gap.
- `on_cycles`=3, `off_time`=2, PRESC=4 → `drive` ends low after the falling edge of half-cycle 3; next SYNC entry 8 cycles after BURST exit.
- Deassert `start` after the 2nd edge of a 10-half-cycle burst → all 10 half-cycles delivered, then IDLE, `busy`=0.
- `gen_out` held at 0, SYNC_TMO=16 → `fault` pulse 16 cycles after SYNC entry, return to IDLE, `drive` stays 0.
- Assert `rst` mid-burst (`drive`=1) → `drive`=0 and `busy`=0 on the next cycle.
- With `BURST_SWEEP_EN`, `freq_param`=0xFE, `on_cycles`=8:
  - `gen_inp` goes 0xFE→0xFF, then holds 0xFF (saturates);
  - `gen_en` pulses at each rise after the first.
